// File: rtl/pipelined_adder_arbiter.sv
// Round-robin front end that shares one external pipelined adder between several requesters.
// Operands are registered onto the adder; a matching tag pipe returns each sum with its owner id.
module pipelined_adder_arbiter #(
  parameter int unsigned inp_data_width = 8,
  parameter int unsigned num_req        = 4,
  parameter int unsigned adder_latency  = 2,
  parameter int unsigned id_width       = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               hold,
  input  logic [num_req-1:0]                 req_valid,
  input  logic [num_req*inp_data_width-1:0]  req_inp1,
  input  logic [num_req*inp_data_width-1:0]  req_inp2,
  output logic [num_req-1:0]                 req_ready,
  output logic [inp_data_width-1:0]          add_inp1,
  output logic [inp_data_width-1:0]          add_inp2,
  input  logic [inp_data_width:0]            add_outp,
  output logic                               rsp_valid,
  output logic [id_width-1:0]                rsp_id,
  output logic [inp_data_width:0]            rsp_data,
  output logic                               busy
);

  // Stage 0 is the issue register; the last stage lines up with the adder output.
  localparam int unsigned NumStages = adder_latency + 1;

  logic [id_width-1:0]                     last_grant_q, last_grant_d;
  logic [inp_data_width-1:0]               add_inp1_q, add_inp1_d;
  logic [inp_data_width-1:0]               add_inp2_q, add_inp2_d;
  logic [NumStages-1:0]                    vld_q, vld_d;
  logic [NumStages-1:0][id_width-1:0]      id_q, id_d;

  logic                                    grant_vld;
  logic [id_width-1:0]                     grant_idx;
  logic [num_req-1:0]                      grant;

  // Round-robin search starting just after the previous winner.
  always_comb begin
    logic [id_width-1:0] cand;
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (!hold) begin
      for (int unsigned k = 1; k <= num_req; k++) begin
        cand = id_width'((32'(last_grant_q) + k) % num_req);
        if (!grant_vld && req_valid[cand]) begin
          grant_vld = 1'b1;
          grant_idx = cand;
        end
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int unsigned i = 0; i < num_req; i++) begin
      if (grant_vld && (grant_idx == id_width'(i))) begin
        grant[i] = 1'b1;
      end
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    add_inp1_d   = add_inp1_q;
    add_inp2_d   = add_inp2_q;
    if (grant_vld) begin
      last_grant_d = grant_idx;
      for (int unsigned i = 0; i < num_req; i++) begin
        if (grant_idx == id_width'(i)) begin
          add_inp1_d = req_inp1[i*inp_data_width +: inp_data_width];
          add_inp2_d = req_inp2[i*inp_data_width +: inp_data_width];
        end
      end
    end
    vld_d = {vld_q[NumStages-2:0], grant_vld};
    id_d  = {id_q[NumStages-2:0], grant_idx};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= id_width'(num_req - 1);
      add_inp1_q   <= '0;
      add_inp2_q   <= '0;
      vld_q        <= '0;
      id_q         <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      add_inp1_q   <= add_inp1_d;
      add_inp2_q   <= add_inp2_d;
      vld_q        <= vld_d;
      id_q         <= id_d;
    end
  end

  // Ready is forced low while reset is asserted so no transfer is seen during reset.
  assign req_ready = grant & {num_req{rst_n}};
  assign add_inp1  = add_inp1_q;
  assign add_inp2  = add_inp2_q;
  assign rsp_valid = vld_q[NumStages-1];
  assign rsp_id    = id_q[NumStages-1];
  assign rsp_data  = add_outp;
  assign busy      = |vld_q;

endmodule

// File: tb/tb_pipelined_adder_arbiter.sv
// Bench for pipelined_adder_arbiter: grant vectors from a table, responses via a scoreboard
// fed by a two-register adder model.
module tb_pipelined_adder_arbiter;

  logic        clk;
  logic        rst_n;
  logic        hold;
  logic [3:0]  req_valid;
  logic [31:0] req_inp1;
  logic [31:0] req_inp2;
  logic [3:0]  req_ready;
  logic [7:0]  add_inp1;
  logic [7:0]  add_inp2;
  logic [8:0]  add_outp;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [8:0]  rsp_data;
  logic        busy;

  int nchecks = 0;
  int nerrs   = 0;
  int cyc     = 0;

  pipelined_adder_arbiter #(
    .inp_data_width(8),
    .num_req       (4),
    .adder_latency (2),
    .id_width      (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .hold     (hold),
    .req_valid(req_valid),
    .req_inp1 (req_inp1),
    .req_inp2 (req_inp2),
    .req_ready(req_ready),
    .add_inp1 (add_inp1),
    .add_inp2 (add_inp2),
    .add_outp (add_outp),
    .rsp_valid(rsp_valid),
    .rsp_id   (rsp_id),
    .rsp_data (rsp_data),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Two-register adder model (latency 2).
  logic [8:0] s1, s2;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= {1'b0, add_inp1} + {1'b0, add_inp2};
      s2 <= s1;
    end
  end
  assign add_outp = s2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrs++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    int         due;
    logic [1:0] id;
    logic [8:0] data;
  } exp_t;
  exp_t sb[$];

  // Scoreboard: check due responses and busy, then record this cycle's transfer.
  always @(negedge clk) begin
    if (rst_n) begin
      automatic logic [3:0] xfer = req_valid & req_ready;
      check("busy", 32'(busy), 32'(sb.size() != 0));
      if (sb.size() > 0 && sb[0].due == cyc) begin
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_id", 32'(rsp_id), 32'(sb[0].id));
        check("rsp_data", 32'(rsp_data), 32'(sb[0].data));
        void'(sb.pop_front());
      end else begin
        check("rsp_valid_idle", 32'(rsp_valid), 32'd0);
      end
      for (int i = 0; i < 4; i++) begin
        if (xfer[i]) begin
          automatic exp_t e;
          e.due  = cyc + 3;
          e.id   = 2'(i);
          e.data = {1'b0, req_inp1[i*8 +: 8]} + {1'b0, req_inp2[i*8 +: 8]};
          sb.push_back(e);
        end
      end
    end
  end

  typedef struct {
    logic        hold;
    logic [3:0]  valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  exp_ready;
  } vec_t;
  vec_t vecs[15];

  initial begin
    automatic logic [31:0] ops10 = {8'd13, 8'd12, 8'd11, 8'd10};
    // single op, idle, four-way rotation, wrap with 1001, overflow/zero, hold, resume
    vecs[0]  = '{1'b0, 4'b0001, 32'h0000_0003, 32'h0000_0004, 4'b0001};
    vecs[1]  = '{1'b0, 4'b0000, 32'h0,         32'h0,         4'b0000};
    vecs[2]  = '{1'b0, 4'b1111, ops10,         ops10,         4'b0010};
    vecs[3]  = '{1'b0, 4'b1111, ops10,         ops10,         4'b0100};
    vecs[4]  = '{1'b0, 4'b1111, ops10,         ops10,         4'b1000};
    vecs[5]  = '{1'b0, 4'b1111, ops10,         ops10,         4'b0001};
    vecs[6]  = '{1'b0, 4'b1001, ops10,         ops10,         4'b1000};
    vecs[7]  = '{1'b0, 4'b1001, ops10,         ops10,         4'b0001};
    vecs[8]  = '{1'b0, 4'b1001, ops10,         ops10,         4'b1000};
    vecs[9]  = '{1'b0, 4'b0001, 32'h0000_00FF, 32'h0000_00FF, 4'b0001};
    vecs[10] = '{1'b0, 4'b0001, 32'h0000_0000, 32'h0000_0000, 4'b0001};
    vecs[11] = '{1'b1, 4'b1111, ops10,         ops10,         4'b0000};
    vecs[12] = '{1'b1, 4'b1111, ops10,         ops10,         4'b0000};
    vecs[13] = '{1'b1, 4'b1111, ops10,         ops10,         4'b0000};
    vecs[14] = '{1'b0, 4'b1111, ops10,         ops10,         4'b0010};

    rst_n     = 1'b0;
    hold      = 1'b0;
    req_valid = 4'b1111;
    req_inp1  = ops10;
    req_inp2  = ops10;
    #2;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_add_inp1", 32'(add_inp1), 32'd0);
    check("rst_add_inp2", 32'(add_inp2), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    #2;
    req_valid = 4'b0000;
    rst_n     = 1'b1;

    for (int v = 0; v < 15; v++) begin
      @(posedge clk);
      #1;
      hold      = vecs[v].hold;
      req_valid = vecs[v].valid;
      req_inp1  = vecs[v].a;
      req_inp2  = vecs[v].b;
      @(negedge clk);
      check($sformatf("ready_vec%0d", v), 32'(req_ready), 32'(vecs[v].exp_ready));
    end

    // Mid-flight reset: two ops issued, then reset before either returns.
    @(posedge clk);
    #1;
    hold      = 1'b0;
    req_valid = 4'b0011;
    @(negedge clk);
    check("pre_rst_grant0", 32'(req_ready), 32'b0001);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("pre_rst_grant1", 32'(req_ready), 32'b0010);
    @(posedge clk);
    #1;
    req_valid = 4'b1111;
    rst_n     = 1'b0;
    sb.delete();
    #1;
    check("midrst_ready", 32'(req_ready), 32'd0);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_add_inp1", 32'(add_inp1), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_grant", 32'(req_ready), 32'b0001);
    @(posedge clk);
    #1;
    req_valid = 4'b0000;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end

endmodule
